// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: accepts one instruction, decodes it, and
// sequences the ALU, the data memory, register writeback and the PC update.
module rv32i_multicycle_ctrl #(
    parameter logic RESET_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_ctr,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [31:0] imm,
    input  logic        alu_zero,
    input  logic        alu_less,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        ready_q, ready_d;
    logic [3:0]  alu_ctr_q, alu_ctr_d;
    logic [31:0] imm_q, imm_d;
    logic        a_sel_q, a_sel_d;
    logic        b_sel_q, b_sel_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        reg_we_q, reg_we_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        pc_we_q, pc_we_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  dec_ctr;
    logic [31:0] dec_imm;
    logic        dec_a, dec_b, dec_bad;
    logic [1:0]  dec_wb, dec_pc;
    logic        taken;

    assign opcode = ir_q[6:0];
    assign f3     = ir_q[14:12];
    assign f7     = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    // funct3[2] picks Less over Zero, funct3[0] inverts the condition
    assign taken = (f3[2] ? alu_less : alu_zero) ^ f3[0];

    function automatic logic [3:0] alu_fn(input logic [2:0] fn,
                                          input logic alt);
        logic [3:0] r;
        case (fn)
            3'b000:  r = alt ? 4'b1000 : 4'b0000;
            3'b001:  r = 4'b0001;
            3'b010:  r = 4'b0010;
            3'b011:  r = 4'b1010;
            3'b100:  r = 4'b0100;
            3'b101:  r = alt ? 4'b1101 : 4'b0101;
            3'b110:  r = 4'b0110;
            default: r = 4'b0111;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_ctr = 4'b0000;
        dec_imm = 32'd0;
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_wb  = 2'd0;
        dec_pc  = 2'd0;
        dec_bad = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_ctr = 4'b0011;
                dec_imm = imm_u;
                dec_b   = 1'b1;
            end
            OP_AUIPC: begin
                dec_imm = imm_u;
                dec_a   = 1'b1;
                dec_b   = 1'b1;
            end
            OP_JAL: begin
                dec_imm = imm_j;
                dec_wb  = 2'd2;
                dec_pc  = 2'd1;
            end
            OP_JALR: begin
                dec_imm = imm_i;
                dec_b   = 1'b1;
                dec_wb  = 2'd2;
                dec_pc  = 2'd2;
            end
            OP_BRANCH: begin
                dec_imm = imm_b;
                case (f3[2:1])
                    2'b10:   dec_ctr = 4'b0010;
                    2'b11:   dec_ctr = 4'b1010;
                    default: dec_ctr = 4'b1000;
                endcase
            end
            OP_LOAD: begin
                dec_imm = imm_i;
                dec_b   = 1'b1;
                dec_wb  = 2'd1;
            end
            OP_STORE: begin
                dec_imm = imm_s;
                dec_b   = 1'b1;
            end
            OP_IMM: begin
                dec_imm = imm_i;
                dec_b   = 1'b1;
                dec_ctr = alu_fn(f3, f7[5] && f3 == 3'b101);
                dec_bad = (f3 == 3'b001 || f3 == 3'b101) &&
                          f7 != 7'h00 && f7 != 7'h20;
            end
            OP_REG: begin
                dec_ctr = alu_fn(f3, f7[5]);
                dec_bad = (f7 != 7'h00 && f7 != 7'h20) ||
                          (f7 == 7'h20 && f3 != 3'b000 &&
                           f3 != 3'b101);
            end
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_ctr_d = alu_ctr_q;
        imm_d     = imm_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        wb_sel_d  = wb_sel_q;
        pc_sel_d  = pc_sel_q;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        reg_we_d  = 1'b0;
        pc_we_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (instr_valid && ready_q) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_bad) begin
                    illegal_d = 1'b1;
                    pc_we_d   = 1'b1;
                    pc_sel_d  = 2'd0;
                    state_d   = S_FETCH;
                end else begin
                    alu_ctr_d = dec_ctr;
                    imm_d     = dec_imm;
                    a_sel_d   = dec_a;
                    b_sel_d   = dec_b;
                    wb_sel_d  = dec_wb;
                    pc_sel_d  = dec_pc;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_we_d  = 1'b1;
                    pc_sel_d = taken ? 2'd1 : 2'd0;
                    state_d  = S_FETCH;
                end else if (opcode == OP_LOAD ||
                             opcode == OP_STORE) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = (opcode == OP_STORE);
                    state_d   = S_MEM;
                end else begin
                    reg_we_d = 1'b1;
                    pc_we_d  = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_ack) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end else if (mem_we_q) begin
                    pc_we_d  = 1'b1;
                    pc_sel_d = 2'd0;
                    state_d  = S_FETCH;
                end else begin
                    reg_we_d = 1'b1;
                    pc_we_d  = 1'b1;
                    state_d  = S_WB;
                end
            end
            default: state_d = S_FETCH;
        endcase
        ready_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            ready_q   <= 1'b0;
            alu_ctr_q <= 4'd0;
            imm_q     <= 32'd0;
            a_sel_q   <= 1'b0;
            b_sel_q   <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            wb_sel_q  <= 2'd0;
            pc_we_q   <= 1'b0;
            pc_sel_q  <= 2'd0;
            illegal_q <= RESET_ILLEGAL;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ready_q   <= ready_d;
            alu_ctr_q <= alu_ctr_d;
            imm_q     <= imm_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            reg_we_q  <= reg_we_d;
            wb_sel_q  <= wb_sel_d;
            pc_we_q   <= pc_we_d;
            pc_sel_q  <= pc_sel_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_ctr     = alu_ctr_q;
    assign imm         = imm_q;
    assign alu_a_sel   = a_sel_q;
    assign alu_b_sel   = b_sel_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign reg_we      = reg_we_q;
    assign wb_sel      = wb_sel_q;
    assign pc_we       = pc_we_q;
    assign pc_sel      = pc_sel_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: hand-encoded instructions with
// hand-computed control outputs, checked cycle by cycle after each edge.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  alu_ctr;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [31:0] imm;
    logic        alu_zero;
    logic        alu_less;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    int mreq_cnt;

    rv32i_multicycle_ctrl dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .alu_ctr(alu_ctr),
        .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel),
        .imm(imm),
        .alu_zero(alu_zero),
        .alu_less(alu_less),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_ack(mem_ack),
        .reg_we(reg_we),
        .wb_sel(wb_sel),
        .pc_we(pc_we),
        .pc_sel(pc_sel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a word, wait (bounded) for ready, return in the DECODE cycle
    task automatic issue(input logic [31:0] w);
        int n;
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        alu_zero = 1'b0;
        alu_less = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_strobes", {28'd0, reg_we, pc_we, mem_req, mem_we}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_ready", {31'd0, instr_ready}, 32'd1);

        // SUB x3, x1, x2
        issue(32'h402081B3);
        chk("sub_dec_rwe", {31'd0, reg_we}, 32'd0);
        tick();
        chk("sub_ctr", {28'd0, alu_ctr}, 32'h8);
        chk("sub_bsel", {31'd0, alu_b_sel}, 32'd0);
        chk("sub_ex_pwe", {31'd0, pc_we}, 32'd0);
        tick();
        chk("sub_wb_strobes", {30'd0, reg_we, pc_we}, 32'h3);
        chk("sub_wbsel", {30'd0, wb_sel}, 32'd0);
        chk("sub_pcsel", {30'd0, pc_sel}, 32'd0);
        tick();
        chk("sub_after", {29'd0, reg_we, pc_we, instr_ready}, 32'h1);

        // BNE x1, x2, +8 with Zero set: not taken
        alu_zero = 1'b1;
        issue(32'h00209463);
        tick();
        chk("bne_ctr", {28'd0, alu_ctr}, 32'h8);
        chk("bne_imm", imm, 32'd8);
        tick();
        chk("bne_nt_pwe", {31'd0, pc_we}, 32'd1);
        chk("bne_nt_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("bne_nt_rwe", {31'd0, reg_we}, 32'd0);
        tick();
        chk("bne_pwe_once", {31'd0, pc_we}, 32'd0);

        // Same BNE with Zero clear: taken
        alu_zero = 1'b0;
        issue(32'h00209463);
        tick();
        tick();
        chk("bne_t_pwe", {31'd0, pc_we}, 32'd1);
        chk("bne_t_pcsel", {30'd0, pc_sel}, 32'd1);
        chk("bne_t_rwe", {31'd0, reg_we}, 32'd0);

        // BLTU x1, x2, +8 with Less set
        alu_less = 1'b1;
        issue(32'h0020E463);
        tick();
        chk("bltu_ctr", {28'd0, alu_ctr}, 32'hA);
        tick();
        chk("bltu_pwe", {31'd0, pc_we}, 32'd1);
        chk("bltu_pcsel", {30'd0, pc_sel}, 32'd1);
        alu_less = 1'b0;

        // SRAI encoding with funct7 0000001: illegal
        issue(32'h0240D193);
        chk("ill_dec", {31'd0, illegal}, 32'd0);
        tick();
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_pwe", {31'd0, pc_we}, 32'd1);
        chk("ill_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("ill_rwe", {31'd0, reg_we}, 32'd0);
        tick();
        chk("ill_once", {30'd0, illegal, pc_we}, 32'd0);

        // SRAI x3, x1, 4
        issue(32'h4040D193);
        tick();
        chk("srai_ctr", {28'd0, alu_ctr}, 32'hD);
        chk("srai_bsel", {31'd0, alu_b_sel}, 32'd1);
        tick();
        chk("srai_rwe", {31'd0, reg_we}, 32'd1);
        chk("srai_ill", {31'd0, illegal}, 32'd0);

        // LW x5, -4(x1), ack in the fourth MEM cycle
        issue(32'hFFC0A283);
        tick();
        chk("lw_imm", imm, 32'hFFFF_FFFC);
        chk("lw_ctr", {28'd0, alu_ctr}, 32'h0);
        mreq_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req === 1'b1) mreq_cnt++;
            chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
            chk("lw_wait_rwe", {31'd0, reg_we}, 32'd0);
            if (i == 3) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        chk("lw_req_cycles", mreq_cnt, 32'd4);
        chk("lw_req_drop", {31'd0, mem_req}, 32'd0);
        chk("lw_wb_strobes", {30'd0, reg_we, pc_we}, 32'h3);
        chk("lw_wbsel", {30'd0, wb_sel}, 32'd1);
        chk("lw_pcsel", {30'd0, pc_sel}, 32'd0);

        // LUI x7, 0x12345
        issue(32'h123453B7);
        tick();
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_ctr", {28'd0, alu_ctr}, 32'h3);
        chk("lui_sel", {30'd0, alu_a_sel, alu_b_sel}, 32'h1);

        // JALR x1, 0(x5)
        tick();
        issue(32'h000280E7);
        tick();
        tick();
        chk("jalr_rwe", {31'd0, reg_we}, 32'd1);
        chk("jalr_pcsel", {30'd0, pc_sel}, 32'd2);
        chk("jalr_wbsel", {30'd0, wb_sel}, 32'd2);

        // SW x2, 8(x1), ack on the first MEM cycle
        tick();
        issue(32'h0020A423);
        tick();
        chk("sw_imm", imm, 32'd8);
        tick();
        chk("sw_req", {30'd0, mem_req, mem_we}, 32'h3);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sw_pwe", {31'd0, pc_we}, 32'd1);
        chk("sw_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("sw_done", {29'd0, mem_req, reg_we, instr_ready}, 32'h1);

        // Same store, reset while waiting for ack
        issue(32'h0020A423);
        tick();
        tick();
        tick();
        chk("swr_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("swr_async", {27'd0, mem_req, mem_we, reg_we, pc_we,
                          instr_ready}, 32'd0);
        chk("swr_regs", {imm[27:0], alu_ctr}, 32'd0);
        chk("swr_sels", {26'd0, alu_a_sel, alu_b_sel, wb_sel, pc_sel}
                        | {31'd0, illegal}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("swr_ready", {31'd0, instr_ready}, 32'd1);
        chk("swr_nostrobe", {29'd0, reg_we, pc_we, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
